operand_load_fsm: RTL and testbench
===================================

Name: operand_load_fsm

Overview:
- Moore control FSM that sequences a three-step operation: load operand A, load operand B, execute.
- Each step raises one enable (habA, habB, habOp) and waits for its completion flag (fimA, fimB, fimOp).
- Sits between a datapath (operand registers and operation unit) and the datapath's handshake flags.
- Optional watchdog traps to an error state if a step stalls.

Parameters:
- TIMEOUT, 0: max cycles in any wait state before trapping to ERR; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-low reset.
- fimA  input  1  operand A load complete.
- fimB  input  1  operand B load complete.
- fimOp  input  1  operation complete.
- habA  output  1  enable load of operand A.
- habB  output  1  enable load of operand B.
- habOp  output  1  enable operation.
- done  output  1  one-cycle pulse after the operation completes.
- err  output  1  watchdog trap flag.
- state  output  3  current state encoding, for debug.

Behaviour:
- Clocking: one clock domain. rst low asynchronously forces state=LOAD_A and clears the watchdog counter. Leaving reset is synchronous on the first rising edge with rst high.
- States and encodings: LOAD_A=0, LOAD_B=1, EXEC=2, DONE=3, ERR=4. Encodings 5–7 are illegal and return to LOAD_A on the next edge.
- Outputs: pure Moore decode of the state register, no input-to-output combinational path.
  - LOAD_A: habA=1.
  - LOAD_B: habB=1.
  - EXEC: habOp=1.
  - DONE: done=1.
  - ERR: err=1.
  - All other outputs are 0 in each state.
  - During and right after reset: habA=1, all other outputs 0, state=0.
- Transitions (evaluated on the rising edge):
  - LOAD_A: fimA=1 → LOAD_B, else stay.
  - LOAD_B: fimB=1 → EXEC, else stay.
  - EXEC: fimOp=1 → DONE, else stay.
  - DONE: unconditional → LOAD_A. The done pulse is exactly 1 cycle.
  - ERR: stays until reset. Completion flags are ignored.
- Only the flag belonging to the current state is examined; the other flags are don't-care.
- At most one state advance per clock. With fimA=fimB=fimOp=1 held, the sequence is LOAD_A→LOAD_B→EXEC→DONE→LOAD_A, one state per cycle.
- Flags are level-sensitive. A flag already high when its state is entered causes an exit on the first edge in that state, so the enable is high for 1 cycle.
- Watchdog (TIMEOUT>0):
  - Counter width is clog2(TIMEOUT+1).
  - The counter clears on every state change.
  - On each edge in LOAD_A, LOAD_B or EXEC with that state's flag low: if count==TIMEOUT-1, next state is ERR; otherwise count increments.
  - Net effect: an enable stays high for at most TIMEOUT cycles.
  - A flag arriving on the trap edge has priority and advances normally.
- Watchdog (TIMEOUT=0): no counter logic; ERR is unreachable.
- Reset mid-operation from any state, including ERR, returns to LOAD_A immediately, without waiting for a clock edge.

Test Plan:
- Reset and stall: rst=0 for 12 ns, then release with all flags 0 → habA=1, state=0, holding indefinitely (TIMEOUT=0).
- Normal sequence:
  - fimA=1 → next edge habB=1, state=1.
  - fimB=1 → habOp=1, state=2.
  - fimOp held 0 → stays in EXEC.
  - fimOp=1 → done=1 for exactly one cycle, state=3, then habA=1, state=0.
- Flags held high: fimA=fimB=fimOp=1 held → habA, habB, habOp and done each high for exactly 1 cycle in order, repeating every 4 cycles.
- Out-of-order flag: fimB=1 while in LOAD_A with fimA=0 → no transition, habA stays 1.
- Watchdog: TIMEOUT=4, fimA held 0 → habA high 4 cycles, then state=4 and err=1 held. Flags ignored; asserting rst → state=0, habA=1.
- Async reset mid-operation: reset asserted mid-cycle while in EXEC → habOp drops and habA rises before the next clock edge.

Source files
------------

// File: rtl/operand_load_fsm.sv
// Moore control FSM sequencing load-A, load-B and execute steps of a datapath,
// with an optional watchdog that traps to ERR when a step stalls too long.
module operand_load_fsm #(
  parameter int TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fimA,
  input  logic       fimB,
  input  logic       fimOp,
  output logic       habA,
  output logic       habB,
  output logic       habOp,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  localparam logic [2:0] LOAD_A = 3'd0;
  localparam logic [2:0] LOAD_B = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       trap;

  // Next-state selection; a completion flag always wins over a watchdog trap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A: begin
        if (fimA)      state_d = LOAD_B;
        else if (trap) state_d = ERR;
      end
      LOAD_B: begin
        if (fimB)      state_d = EXEC;
        else if (trap) state_d = ERR;
      end
      EXEC: begin
        if (fimOp)     state_d = DONE;
        else if (trap) state_d = ERR;
      end
      DONE:    state_d = LOAD_A;
      ERR:     state_d = ERR;
      default: state_d = LOAD_A;
    endcase
  end

  // State register, forced back to LOAD_A the moment reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD_A;
    else      state_q <= state_d;
  end

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          stalled;

      // Count consecutive stalled edges; any state change restarts the count.
      always_comb begin
        cnt_d   = '0;
        trap    = 1'b0;
        stalled = ((state_q == LOAD_A) && !fimA) ||
                  ((state_q == LOAD_B) && !fimB) ||
                  ((state_q == EXEC)   && !fimOp);
        if (stalled) begin
          if (cnt_q == LIMIT) trap = 1'b1;
          else                cnt_d = cnt_q + 1'b1;
        end
      end

      // Watchdog counter register, cleared with the state on reset.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
      end
    end else begin : g_no_watchdog
      assign trap = 1'b0;
    end
  endgenerate

  assign habA  = (state_q == LOAD_A);
  assign habB  = (state_q == LOAD_B);
  assign habOp = (state_q == EXEC);
  assign done  = (state_q == DONE);
  assign err   = (state_q == ERR);
  assign state = state_q;

endmodule

// File: tb/tb_operand_load_fsm.sv
// Self-checking bench: two instances (watchdog off, TIMEOUT=4) driven side by
// side and compared every cycle against a step-sequence reference model.
module tb_operand_load_fsm;

  logic clk;
  logic rst;
  logic fimA0, fimB0, fimOp0;
  logic habA0, habB0, habOp0, done0, err0;
  logic [2:0] state0;
  logic fimA4, fimB4, fimOp4;
  logic habA4, habB4, habOp4, done4, err4;
  logic [2:0] state4;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model: step index (0=A,1=B,2=op,3=done,4=error) and stall count.
  int ph0 = 0, w0 = 0;
  int ph4 = 0, w4 = 0;

  operand_load_fsm #(.TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .fimA(fimA0), .fimB(fimB0), .fimOp(fimOp0),
    .habA(habA0), .habB(habB0), .habOp(habOp0), .done(done0), .err(err0),
    .state(state0)
  );

  operand_load_fsm #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .fimA(fimA4), .fimB(fimB4), .fimOp(fimOp4),
    .habA(habA4), .habB(habB4), .habOp(habOp4), .done(done4), .err(err4),
    .state(state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic advance(inout int ph, inout int w, input int tmo, input logic [2:0] fl);
    if (ph == 4) begin
      w = 0;
    end else if (ph == 3) begin
      ph = 0;
      w  = 0;
    end else if (fl[ph]) begin
      ph = ph + 1;
      w  = 0;
    end else if (tmo > 0 && w == tmo - 1) begin
      ph = 4;
      w  = 0;
    end else begin
      w = w + 1;
    end
  endtask

  function automatic logic [7:0] expVec(int ph);
    logic [2:0] s;
    s = ph[2:0];
    return {s, ph == 0, ph == 1, ph == 2, ph == 3, ph == 4};
  endfunction

  task automatic modelReset();
    ph0 = 0; w0 = 0;
    ph4 = 0; w4 = 0;
  endtask

  // Flags are packed {fimOp, fimB, fimA}
  task automatic applyStimulus(input logic [2:0] f0, input logic [2:0] f4);
    {fimOp0, fimB0, fimA0} = f0;
    {fimOp4, fimB4, fimA4} = f4;
    @(posedge clk);
    if (rst) begin
      advance(ph0, w0, 0, f0);
      advance(ph4, w4, 4, f4);
    end else begin
      modelReset();
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {state0, habA0, habB0, habOp0, done0, err0};
    exp = expVec(ph0);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s t0: observed %b expected %b", tag, obs, exp);
    end
    obs = {state4, habA4, habB4, habOp4, done4, err4};
    exp = expVec(ph4);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s t4: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic midCycleReset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] r0, r4;
    rst = 1'b0;
    {fimOp0, fimB0, fimA0} = 3'b000;
    {fimOp4, fimB4, fimA4} = 3'b000;
    #3;
    checkOutput("reset_active");
    #9;
    rst = 1'b1;

    // Stall in LOAD_A; TIMEOUT=4 instance counts to its last allowed edge
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b000, 3'b000);
      checkOutput("stall_load_a");
    end
    // Flag on the would-be trap edge advances normally
    applyStimulus(3'b001, 3'b001); checkOutput("to_load_b");
    applyStimulus(3'b010, 3'b010); checkOutput("to_exec");
    applyStimulus(3'b000, 3'b000); checkOutput("exec_hold");
    applyStimulus(3'b000, 3'b000); checkOutput("exec_hold");
    applyStimulus(3'b100, 3'b100); checkOutput("to_done");
    applyStimulus(3'b000, 3'b000); checkOutput("back_load_a");
    applyStimulus(3'b010, 3'b110); checkOutput("out_of_order");
    applyStimulus(3'b110, 3'b010); checkOutput("out_of_order");

    // All flags held: one state per cycle, repeating every 4
    for (int i = 0; i < 9; i++) begin
      applyStimulus(3'b111, 3'b111);
      checkOutput("flags_high");
    end
    // Settle both into EXEC, then reset mid-cycle
    while (ph0 != 2 || ph4 != 2) begin
      applyStimulus({2'b01, ph0 == 0}, {2'b01, ph4 == 0});
      checkOutput("reach_exec");
      if (checkCount > 40) break;
    end
    midCycleReset("async_reset_exec");

    // Watchdog trap after 4 stalled cycles
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b000, 3'b000);
      checkOutput("watchdog");
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b000, 3'b111);
      checkOutput("err_hold");
    end
    midCycleReset("async_reset_err");

    // Randomized flags with periodic mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      r0 = 3'($urandom_range(0, 7));
      r4 = 3'($urandom_range(0, 7));
      applyStimulus(r0, r4);
      checkOutput("random");
      if (i % 37 == 36) midCycleReset("random_reset");
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
